// File: rtl/overload_guard.sv
// rtl/overload_guard.sv - emergency-stage controller downstream of the weight-limit counter
//
// Purpose:
//   Reacts to an overload level from the weight counter.
//   Stops the car and holds the doors open while sounding the alarm.
//   After the operator acknowledges, it clears the counter with a one-cycle pulse.
//   It then keeps the car out of service for a fixed grace period.
//
// Parameters:
//   GRACE_CYCLES  cycles spent in GRACE after the counter is cleared (1..65535)
//   BLINK_HALF    alarm on/off half-period in cycles (1..65535), blink build only
//
// Optional build macro:
//   OVERLOAD_GUARD_ALARM_BLINK_EN  alarm blinks in STOPPING/ALARM instead of a steady 1
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous active-high reset
//   weight_limit_exceeded  overload level from the weight counter
//   elevator_moving        car-in-motion level from the motion controller
//   alarm_ack              operator acknowledge (any pulse width)
//   reset_weight_flip      one-cycle clear pulse to the weight counter
//   block_motion           stop at next floor / do not start
//   hold_doors             doors forced/held open
//   alarm                  buzzer/lamp drive
//   overload_active        state is not IDLE
//   overload_events        saturating count of overload entries

module overload_guard #(
    parameter int GRACE_CYCLES = 50,
    parameter int BLINK_HALF   = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       weight_limit_exceeded,
    input  logic       elevator_moving,
    input  logic       alarm_ack,
    output logic       reset_weight_flip,
    output logic       block_motion,
    output logic       hold_doors,
    output logic       alarm,
    output logic       overload_active,
    output logic [3:0] overload_events
);

    localparam int TW = $clog2(GRACE_CYCLES) + 1;

    // Elaboration-time guard against out-of-range configuration.
    if (GRACE_CYCLES < 1 || GRACE_CYCLES > 65535) begin : g_bad_grace
        $error("overload_guard: GRACE_CYCLES out of range");
    end
    if (BLINK_HALF < 1 || BLINK_HALF > 65535) begin : g_bad_blink
        $error("overload_guard: BLINK_HALF out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOPPING,
        S_ALARM,
        S_CLEARING,
        S_GRACE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          count_en;
    logic          alarm_zone;

    // ------------------------------------------------------------------
    // State, timer and event counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            timer           <= '0;
            overload_events <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (count_en && overload_events != 4'hF) begin
                overload_events <= overload_events + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        timer_next = timer;
        count_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (weight_limit_exceeded) begin
                    count_en   = 1'b1;
                    state_next = elevator_moving ? S_STOPPING : S_ALARM;
                end
            end
            S_STOPPING: begin
                if (!elevator_moving) begin
                    state_next = S_ALARM;
                end
            end
            S_ALARM: begin
                if (alarm_ack) begin
                    if (weight_limit_exceeded) begin
                        state_next = S_CLEARING;
                    end else begin
                        state_next = S_GRACE;
                        timer_next = TW'(GRACE_CYCLES - 1);
                    end
                end
            end
            S_CLEARING: begin
                state_next = S_GRACE;
                timer_next = TW'(GRACE_CYCLES - 1);
            end
            S_GRACE: begin
                // A fresh overload outranks the timer expiring on the same cycle.
                if (weight_limit_exceeded) begin
                    state_next = S_ALARM;
                end else if (timer == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign alarm_zone = (state == S_STOPPING) || (state == S_ALARM);

`ifdef OVERLOAD_GUARD_ALARM_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF) + 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          zone_entry;

    // STOPPING -> ALARM and GRACE -> ALARM both count as fresh entries,
    // so the pattern always restarts with a full "on" half-period.
    assign zone_entry = ((state_next == S_STOPPING) || (state_next == S_ALARM))
                        && (state_next != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (zone_entry) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (alarm_zone) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign alarm = alarm_zone && blink_on;
`else
    assign alarm = alarm_zone;
`endif

    // ------------------------------------------------------------------
    // Moore outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        reset_weight_flip = 1'b0;
        block_motion      = 1'b0;
        hold_doors        = 1'b0;
        case (state)
            S_STOPPING: begin
                block_motion = 1'b1;
            end
            S_ALARM: begin
                block_motion = 1'b1;
                hold_doors   = 1'b1;
            end
            S_CLEARING: begin
                reset_weight_flip = 1'b1;
                block_motion      = 1'b1;
                hold_doors        = 1'b1;
            end
            S_GRACE: begin
                block_motion = 1'b1;
                hold_doors   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign overload_active = (state != S_IDLE);

endmodule

// File: doc/overload_guard.md
Name: overload_guard

Overview:
- Emergency-stage controller directly downstream of the weight-limit counter.
- Consumes `weight_limit_exceeded`.
- Drives motion inhibit, door hold and alarm.
- After operator acknowledgement, issues the one-cycle `reset_weight_flip` pulse back to the counter, then enforces a grace period before returning the car to normal service.

Parameters:
- GRACE_CYCLES, 50, cycles doors stay held and motion stays blocked after the counter is cleared; legal range 1..65535.
- BLINK_HALF, 25, alarm on/off half-period in cycles; used only with ALARM_BLINK_EN; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- weight_limit_exceeded  in  1  level from the weight counter; 1 = overload.
- elevator_moving  in  1  level from the motion controller; 1 = car in motion.
- alarm_ack  in  1  operator acknowledge; any width of pulse accepted.
- reset_weight_flip  out  1  one-cycle clear pulse to the weight counter.
- block_motion  out  1  1 = motion controller must stop at the next floor and not start.
- hold_doors  out  1  1 = doors forced/held open.
- alarm  out  1  buzzer/lamp drive.
- overload_active  out  1  1 whenever state is not IDLE.
- overload_events  out  4  saturating count of overload entries.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE; grace and blink counters are cleared.
  - overload_events becomes 0.
  - All outputs are 0 from the following cycle.
  - Reset mid-operation aborts any state immediately; no reset_weight_flip pulse is emitted.
- Outputs are Moore, decoded from the registered state.
  - Latency: input sampled at edge N, state changes at edge N, outputs reflect the new state during cycle N..N+1.
- State encoding is free; five states:
  - IDLE: all outputs 0.
    - exceeded=1 and moving=1 -> STOPPING.
    - exceeded=1 and moving=0 -> ALARM.
    - On either transition, overload_events increments, saturating at 15.
  - STOPPING: block_motion=1, alarm=1, hold_doors=0.
    - moving=0 -> ALARM.
    - alarm_ack is ignored here.
  - ALARM: block_motion=1, hold_doors=1, alarm=1.
    - alarm_ack=1 and exceeded=1 -> CLEARING.
    - alarm_ack=1 and exceeded=0 -> GRACE, loading the timer with GRACE_CYCLES-1.
  - CLEARING: reset_weight_flip=1, block_motion=1, hold_doors=1, alarm=0.
    - Always -> GRACE next edge, loading the timer with GRACE_CYCLES-1.
    - The pulse is exactly one cycle wide.
  - GRACE: block_motion=1, hold_doors=1, alarm=0.
    - exceeded=1 -> ALARM; timer discarded, overload_events not incremented.
    - Otherwise timer=0 -> IDLE; else timer decrements.
    - GRACE therefore lasts exactly GRACE_CYCLES cycles when undisturbed.
- Simultaneous events:
  - In GRACE, exceeded=1 on the timer-zero cycle: ALARM wins.
  - In ALARM, alarm_ack held high for several cycles: only one CLEARING pass; the ack level is ignored outside ALARM.
  - A new overload while in STOPPING or ALARM is not counted again.
- Width rules:
  - Timer width is $clog2(GRACE_CYCLES)+1.
  - Blink counter width is $clog2(BLINK_HALF)+1.
  - overload_events never wraps.
- overload_active = (state != IDLE).

Optional Feature:
- Macro: OVERLOAD_GUARD_ALARM_BLINK_EN.
- Defined: in STOPPING and ALARM, alarm toggles every BLINK_HALF cycles.
  - Starts at 1 on state entry.
  - The blink counter restarts on every entry to STOPPING or ALARM.
  - In all other states alarm=0.
- Undefined: alarm is a steady 1 in STOPPING and ALARM; no blink counter is synthesised.

Test Plan:
1. Reset then idle: hold reset 2 cycles, all inputs 0 for 20 cycles -> every output 0, overload_events=0.
2. Stationary overload:
   - exceeded=1, moving=0 -> next cycle ALARM: block_motion=1, hold_doors=1, alarm=1, overload_events=1.
   - Then alarm_ack 1 cycle -> reset_weight_flip=1 for exactly 1 cycle.
   - Drop exceeded the cycle after -> hold_doors=1 for 50 more cycles, then all outputs 0.
3. Moving overload: exceeded=1, moving=1 -> block_motion=1, alarm=1, hold_doors=0; alarm_ack ignored; moving->0 after 10 cycles -> hold_doors=1 next cycle.
4. Re-overload in grace: exceeded reasserts at grace cycle 20 -> ALARM next cycle, alarm=1, overload_events unchanged.
5. Saturation: 17 complete overload/ack/grace cycles -> overload_events=15.
6. Reset mid-ALARM: assert reset while in ALARM -> all outputs 0 next cycle, no reset_weight_flip pulse.
   - With OVERLOAD_GUARD_ALARM_BLINK_EN and BLINK_HALF=4: in ALARM, alarm pattern is 1111000011110000.
